// File: rtl/mdu.sv
// Multiply/divide unit: multicycle mult/multu/div/divu plus mthi/mtlo,
// holding the architectural HI/LO registers and exporting busy to the hazard unit.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpRsvd  = 3'd7
  } op_e;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  // Counter preloads: the write-back happens on the edge where the counter reads zero.
  localparam logic [3:0] MultLoad = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES - 1);

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_wr_en;
  logic        r_busy;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_mul_signed;
  logic        w_div_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quo_mag;
  logic [31:0] w_rem_mag;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_zero;
  logic [63:0] w_res;
  logic [3:0]  w_load;

  assign w_is_mul     = (op == OpMult) || (op == OpMultu);
  assign w_is_div     = (op == OpDiv) || (op == OpDivu);
  assign w_mul_signed = (op == OpMult);
  assign w_div_signed = (op == OpDiv);

  // Both multiplies share one 64-bit multiplier; only the operand extension differs.
  assign w_mul_a = {{32{w_mul_signed & A[31]}}, A};
  assign w_mul_b = {{32{w_mul_signed & B[31]}}, B};
  assign w_prod  = w_mul_a * w_mul_b;

  // Signed divide runs on magnitudes through the unsigned divider, then fixes signs.
  // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000, no negation.
  assign w_a_neg    = w_div_signed & A[31];
  assign w_b_neg    = w_div_signed & B[31];
  assign w_dvd      = w_a_neg ? (32'd0 - A) : A;
  assign w_dvs      = w_b_neg ? (32'd0 - B) : B;
  assign w_div_zero = (B == 32'd0);

  // Unsigned magnitude divider; guarded so a zero divisor never produces X
  always_comb begin
    w_quo_mag = 32'd0;
    w_rem_mag = 32'd0;
    if (!w_div_zero) begin
      w_quo_mag = w_dvd / w_dvs;
      w_rem_mag = w_dvd % w_dvs;
    end
  end

  // Quotient truncates toward zero; remainder takes the dividend's sign
  assign w_quo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_quo_mag) : w_quo_mag;
  assign w_rem = w_a_neg ? (32'd0 - w_rem_mag) : w_rem_mag;

  // Select the 64-bit {hi,lo} result and counter preload for the requested operation
  always_comb begin
    w_res  = {w_rem, w_quo};
    w_load = DivLoad;
    if (w_is_mul) begin
      w_res  = w_prod;
      w_load = MultLoad;
    end
  end

  // Control FSM with registered busy/HI/LO; requests arriving in StRun are dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_wr_en  <= 1'b0;
      r_busy   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            if (w_is_mul || w_is_div) begin
              r_res_hi <= w_res[63:32];
              r_res_lo <= w_res[31:0];
              // A zero divisor still burns the full latency but skips write-back
              r_wr_en  <= !(w_is_div && w_div_zero);
              r_cnt    <= w_load;
              r_state  <= StRun;
              r_busy   <= 1'b1;
            end else if (op == OpMthi) begin
              r_hi <= A;
            end else if (op == OpMtlo) begin
              r_lo <= A;
            end
          end
        end
        StRun: begin
          if (r_cnt == 4'd0) begin
            if (r_wr_en) begin
              r_hi <= r_res_hi;
              r_lo <= r_res_lo;
            end
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_mdu;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  mdu #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic on the operand values
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (o)
      3'd1: return sa * sb;
      3'd2: return ua * ub;
      3'd3: if (b == 32'd0) return cur; else return {32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b == 32'd0) return cur; else return {32'(ua % ub), 32'(ua / ub)};
      default: return cur;
    endcase
  endfunction

  task automatic push(input int unsigned due, input logic bsy, input string tag);
    exp_t e;
    e.due  = due;
    e.busy = bsy;
    e.hi   = exp_hi;
    e.lo   = exp_lo;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the first negedge where a new request can be accepted.
  // junk: 0 quiet, 1 mtlo pressure, 2 random requests while the unit is running.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int junk, input string tag);
    int unsigned t0;
    int unsigned n;
    logic [63:0] r;
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    t0    = cyc + 1;
    if (o >= 3'd1 && o <= 3'd4) begin
      n = (o <= 3'd2) ? MultN : DivN;
      for (int unsigned k = 0; k < n; k++) push(t0 + k, 1'b1, tag);
      r = model(o, a, b, {exp_hi, exp_lo});
      exp_hi = r[63:32];
      exp_lo = r[31:0];
      push(t0 + n, 1'b0, tag);
    end else begin
      n = 0;
      if (o == 3'd5) exp_hi = a;
      else if (o == 3'd6) exp_lo = a;
      push(t0, 1'b0, tag);
    end
    @(negedge clk);
    while (cyc < t0 + n) begin
      A = $urandom;
      B = $urandom;
      if (junk == 1) begin
        start = 1'b1;
        op    = 3'd6;
      end else if (junk == 2) begin
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom_range(0, 7));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
  endtask

  task automatic idle();
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    push(cyc + 1, 1'b0, "idle");
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] specials [5];
    specials[0] = 32'h0000_0000;
    specials[1] = 32'h0000_0001;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'h8000_0000;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
    if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
    return $urandom;
  endfunction

  // Monitor: compare the DUT against the scoreboard entry due this cycle
  always begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #2;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      check({e.tag, "_missed"}, cyc, e.due);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      check({e.tag, "_busy"}, 32'(busy), 32'(e.busy));
      check({e.tag, "_hi"}, HI, e.hi);
      check({e.tag, "_lo"}, LO, e.lo);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = 32'd0;
    B     = 32'd0;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0, "mult_neg");
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
    issue(3'd3, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    issue(3'd4, 32'd7, 32'd0, 0, "divu_zero");
    issue(3'd5, 32'h1234_5678, 32'd0, 0, "mthi");
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, 0, "mtlo");
    issue(3'd1, 32'h0000_1234, 32'h0000_0010, 1, "mult_mtlo_drop");
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    issue(3'd0, 32'h5555_5555, 32'd1, 0, "op_none");
    issue(3'd7, 32'h5555_5555, 32'd1, 0, "op_rsvd");
    idle();

    // Asynchronous reset during the third busy cycle of a mult
    issue(3'd5, 32'hCAFE_F00D, 32'd0, 0, "mthi_pre");
    start = 1'b1;
    op    = 3'd1;
    A     = 32'd100;
    B     = 32'd200;
    t0    = cyc + 1;
    for (int unsigned k = 0; k < 3; k++) push(t0 + k, 1'b1, "mult_pre_rst");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    push(cyc + 1, 1'b0, "rst_hold");
    @(negedge clk);
    reset = 1'b1;
    issue(3'd2, 32'd2, 32'd3, 0, "multu_after_rst");

    // Randomized mix, including ignored requests while running
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) idle();
      else issue(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 2, "rand");
    end

    idle();
    idle();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core. It sits directly downstream of the general register file and takes the two read-port values as its operands. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` over multiple cycles and holds the architectural HI/LO registers. It exports `busy` to the hazard unit, which stalls any following HI/LO access.

## Interface
- `MULT_CYCLES`, default 5: cycles from accepted start to HI/LO update for `mult`/`multu`; legal range 1..15.
- `DIV_CYCLES`, default 10: cycles from accepted start to HI/LO update for `div`/`divu`; legal range 1..15.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request strobe, sampled on the rising edge.
- `op`  in  3  operation: 0 none, 1 `mult`, 2 `multu`, 3 `div`, 4 `divu`, 5 `mthi`, 6 `mtlo`, 7 reserved (treated as none).
- `A`  in  32  operand rs (GRF RD1).
- `B`  in  32  operand rt (GRF RD2).
- `busy`  out  1  high while a mult/div is in flight.
- `HI`  out  32  HI register, registered.
- `LO`  out  32  LO register, registered.

## Operation
- FSM states: IDLE, RUN. A 4-bit down-counter `cnt` and 64-bit result holding registers `res_hi`/`res_lo` support them.
- IDLE:
  - `start`=1 with `op` in 1..4 is accepted on the edge. A and B are latched, the result is computed from the latched operands into `res_hi`/`res_lo`, `cnt` loads the matching `*_CYCLES`-1, and the FSM goes to RUN.
  - If the loaded count is 0, i.e. the parameter is 1, HI/LO are written directly from the computed result at the next edge.
  - `start`=1 with `op` 5 writes HI<=A at this edge; with `op` 6 it writes LO<=A at this edge. The FSM stays in IDLE.
  - `op` 0 or 7, or `start`=0, does nothing.
- RUN:
  - Each edge decrements `cnt`.
  - On the edge where `cnt`==0: HI<=`res_hi`, LO<=`res_lo`, FSM goes to IDLE.
  - `start` is ignored entirely in RUN, including `mthi`/`mtlo`. The hazard unit guarantees no issue; the block must still drop such requests.
- Arithmetic:
  - `mult`: signed 32x32 -> 64-bit product, {HI,LO}.
  - `multu`: unsigned 32x32 -> 64-bit product, {HI,LO}.
  - `div`: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - `divu`: unsigned. LO = quotient; HI = remainder.
  - `div` with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no trap.
  - Divide by zero (B==0, `div` or `divu`): the full latency is still consumed, and HI/LO retain their prior values.
- `busy` is a registered output equal to (state==RUN).

## Timing
- Reset (`reset`=0, async): HI=0, LO=0, `busy`=0, FSM=IDLE, `cnt`=0. An in-flight operation is discarded and never written back. Release is synchronous to the next edge; the first `start` is accepted on the first edge with `reset`=1.
- Start accepted at edge T0 → `busy` high from just after T0 through just after edge T0+N, where N is the `*_CYCLES` value. HI/LO change at edge T0+N, and `busy` falls at that same edge. `busy` is therefore high for exactly N cycles.
- N=1: `busy` is still high for one cycle, and HI/LO update at T0+1.
- `mthi`/`mtlo`: HI or LO visible one edge after the request; `busy` is never asserted.
- HI/LO outputs are stable between updates. A and B changing during RUN has no effect.
- Back-to-back: a new start is accepted on the edge where `busy` goes low? No: at that edge the FSM is still in RUN, so the earliest new acceptance is edge T0+N+1.

## Test plan
- Reset, then `mult` A=0xFFFFFFFE (-2), B=3 → `busy` high for 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA at edge T0+5.
- `multu` A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- `div` A=-7 (0xFFFFFFF9), B=2 → `busy` high for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then `divu` A=7, B=0 → after 10 cycles HI/LO unchanged.
- `mthi` A=0x12345678, then `mtlo` A=0x9ABCDEF0 on the next cycle → HI and LO each update one edge after their request; `busy` stays 0. Then `mtlo` issued during a running `mult` → ignored; LO ends with the product only.
- `div` 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `mult` started, `reset` pulled low asynchronously at cycle 3 → `busy`, HI and LO drop to 0 immediately without waiting for a clock edge. No write-back occurs after release, and a new `multu` 2*3 is accepted on the first edge after release: LO=6, HI=0.
